// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg
// Shared definitions for the configuration-chain stream loader:
//   ccff_state_e  - loader FSM state encoding
//   CRC8_POLY     - CRC-8 generator polynomial (x^8 + x^2 + x + 1)
//   crc8_step     - advance a CRC-8 by one serial bit, MSB-first
// The CHECK state is only part of the encoding when CCFF_READBACK_CHECK_EN
// is defined.
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SHIFT = 3'd2,
`ifdef CCFF_READBACK_CHECK_EN
    ST_CHECK = 3'd3,
`endif
    ST_DONE  = 3'd4
  } ccff_state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/ccff_crc8_serial.sv
// ccff_crc8_serial
// Serial CRC-8 accumulator (poly 0x07, init 0x00, MSB-first).
// Ports:
//   i_clk   - clock
//   i_rst_n - asynchronous active-low reset
//   i_bit   - serial data bit
//   i_en    - fold i_bit into the CRC this cycle
//   i_clr   - synchronous clear to 0x00 (wins over i_en)
//   o_crc   - current CRC value
module ccff_crc8_serial
  import ccff_loader_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_bit,
  input  logic       i_en,
  input  logic       i_clr,
  output logic [7:0] o_crc
);

  logic [7:0] r_crc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_crc <= 8'h00;
    else if (i_clr) r_crc <= 8'h00;
    else if (i_en)  r_crc <= crc8_step(r_crc, i_bit);
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/ccff_stream_loader.sv
// ccff_stream_loader
// Loads a CHAIN_LEN-bit configuration chain from a stream of WORD_W-bit host
// words, MSB first. Optional readback check (macro CCFF_READBACK_CHECK_EN):
// after loading, the chain is recirculated once (head <= tail) while both the
// driven bits and the returned bits are CRC-8 summed; crc_ok reports a match.
// Ports:
//   prog_clk  - programming clock
//   pReset_n  - asynchronous active-low reset
//   start     - begin a load (honoured only in IDLE)
//   cfg_data  - configuration word, cfg_valid / cfg_ready handshake
//   ccff_head - serial bit into the chain head
//   shift_en  - chain advances on the next prog_clk edge
//   ccff_tail - serial bit returning from the chain tail
//   busy      - load in progress (FETCH/SHIFT/CHECK)
//   done      - one-cycle completion pulse
//   crc_ok    - readback result (only with CCFF_READBACK_CHECK_EN)
module ccff_stream_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 64
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done
`ifdef CCFF_READBACK_CHECK_EN
  ,
  output logic              crc_ok
`endif
);

  // One counter width wide enough for both the chain length and a word.
  localparam int CW = $clog2(CHAIN_LEN + WORD_W + 1);
  localparam logic [CW-1:0] C_WORD  = CW'(WORD_W);
  localparam logic [CW-1:0] C_CHAIN = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  ccff_state_e       r_state;
  logic [CW-1:0]     r_rem;    // bits left in the chain (reused as CHECK cycle count)
  logic [CW-1:0]     r_bits;   // bits left in the current word
  logic [WORD_W-1:0] r_sreg;
  logic              w_start;

  assign w_start = (r_state == ST_IDLE) && start;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
      r_bits  <= '0;
      r_sreg  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_FETCH;
            r_rem   <= C_CHAIN;
          end
        end
        ST_FETCH: begin
          if (cfg_valid) begin
            r_sreg  <= cfg_data;
            // A short final word keeps only its upper bits; the rest never shift out.
            r_bits  <= (r_rem >= C_WORD) ? C_WORD : r_rem;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_sreg <= r_sreg << 1;
          r_bits <= r_bits - C_ONE;
          r_rem  <= r_rem - C_ONE;
          if (r_bits == C_ONE) begin
            if (r_rem == C_ONE) begin
`ifdef CCFF_READBACK_CHECK_EN
              r_state <= ST_CHECK;
              r_rem   <= C_CHAIN;
`else
              r_state <= ST_DONE;
`endif
            end else begin
              r_state <= ST_FETCH;
            end
          end
        end
`ifdef CCFF_READBACK_CHECK_EN
        ST_CHECK: begin
          r_rem <= r_rem - C_ONE;
          if (r_rem == C_ONE) r_state <= ST_DONE;
        end
`endif
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cfg_ready = (r_state == ST_FETCH);
  assign done      = (r_state == ST_DONE);

`ifdef CCFF_READBACK_CHECK_EN
  logic [7:0] w_crc_tx, w_crc_rx;
  logic       r_crc_ok;

  ccff_crc8_serial u_crc_tx (
    .i_clk   (prog_clk),
    .i_rst_n (pReset_n),
    .i_bit   (r_sreg[WORD_W-1]),
    .i_en    (r_state == ST_SHIFT),
    .i_clr   (w_start),
    .o_crc   (w_crc_tx)
  );

  ccff_crc8_serial u_crc_rx (
    .i_clk   (prog_clk),
    .i_rst_n (pReset_n),
    .i_bit   (ccff_tail),
    .i_en    (r_state == ST_CHECK),
    .i_clr   (w_start),
    .o_crc   (w_crc_rx)
  );

  // The last tail bit is folded in on the same edge that enters DONE, so the
  // compare uses the readback CRC advanced by that bit.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n)
      r_crc_ok <= 1'b0;
    else if (w_start)
      r_crc_ok <= 1'b0;
    else if ((r_state == ST_CHECK) && (r_rem == C_ONE))
      r_crc_ok <= (w_crc_tx == crc8_step(w_crc_rx, ccff_tail));
  end

  assign crc_ok    = r_crc_ok;
  assign shift_en  = (r_state == ST_SHIFT) || (r_state == ST_CHECK);
  assign busy      = (r_state == ST_FETCH) || (r_state == ST_SHIFT) || (r_state == ST_CHECK);
  assign ccff_head = (r_state == ST_SHIFT) ? r_sreg[WORD_W-1] :
                     (r_state == ST_CHECK) ? ccff_tail : 1'b0;
`else
  logic w_unused_tail;
  assign w_unused_tail = ccff_tail;
  assign shift_en  = (r_state == ST_SHIFT);
  assign busy      = (r_state == ST_FETCH) || (r_state == ST_SHIFT);
  assign ccff_head = (r_state == ST_SHIFT) ? r_sreg[WORD_W-1] : 1'b0;
`endif

endmodule
